// File: rtl/log_ram_reader.sv
// Streams the capture RAM out as bytes (MSB byte of each word first) over a
// valid/ready handshake; holds the RAM read enable for the whole dump.
module log_ram_reader #(
    parameter int RAM_WIDTH   = 32,
    parameter int RAM_DEPTH   = 32000,
    parameter int ADDR_W      = 16,
    parameter int RAM_LATENCY = 1
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [ADDR_W-1:0]    i_n_words,
    input  logic                 i_abort,
    output logic                 o_enbl_read,
    output logic [ADDR_W-1:0]    o_read_adrs,
    input  logic [RAM_WIDTH-1:0] i_ram_data,
    output logic [7:0]           o_byte,
    output logic                 o_byte_valid,
    input  logic                 i_byte_ready,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int BYTES = RAM_WIDTH / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_C   = ADDR_W'(RAM_DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BYTES - 1);
    localparam logic [1:0]        LAST_WAIT = 2'(RAM_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      n_q, n_d;
    logic [ADDR_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [RAM_WIDTH-1:0]   shreg_q, shreg_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [1:0]             wait_q, wait_d;

    logic [ADDR_W-1:0]      n_clamp;
    logic [ADDR_W-1:0]      cnt_inc;

    assign n_clamp = (i_n_words > DEPTH_C) ? DEPTH_C : i_n_words;
    assign cnt_inc = cnt_q + ADDR_W'(1);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            shreg_q <= '0;
            idx_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        wait_d  = wait_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    n_d     = n_clamp;
                    cnt_d   = '0;
                    addr_d  = '0;
                    state_d = (n_clamp == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                wait_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == LAST_WAIT) begin
                    shreg_d = i_ram_data;
                    idx_d   = '0;
                    state_d = S_SEND;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            S_SEND: begin
                if (i_byte_ready) begin
                    shreg_d = shreg_q << 8;
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == n_q) begin
                            state_d = S_DONE;
                        end else begin
                            // Address advances only toward another word, so it stops at N-1.
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = S_READ;
                        end
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (i_abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    assign o_enbl_read  = (state_q == S_READ) || (state_q == S_WAIT) || (state_q == S_SEND);
    assign o_read_adrs  = addr_q;
    assign o_byte       = shreg_q[RAM_WIDTH-1 -: 8];
    assign o_byte_valid = (state_q == S_SEND);
    assign o_busy       = (state_q != S_IDLE);
    assign o_done       = (state_q == S_DONE);

endmodule

// File: tb/tb_log_ram_reader.sv
// Bench for log_ram_reader: table of dump scenarios, hand-written reset/abort
// sequences and randomized dumps checked against a byte-stream model.
module tb_log_ram_reader;

    localparam int DEPTH = 64;
    localparam int AW    = 16;
    localparam int LIMIT = 3000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_start;
    logic [AW-1:0] i_n_words;
    logic          i_abort;
    logic          o_enbl_read;
    logic [AW-1:0] o_read_adrs;
    logic [31:0]   ram_q;
    logic [7:0]    o_byte;
    logic          o_byte_valid;
    logic          i_byte_ready;
    logic          o_busy;
    logic          o_done;

    logic [31:0]   mem [DEPTH];

    int checks = 0;
    int errors = 0;

    logic [7:0] got_bytes [$];
    int   addr_err, stab_err, enbl_gap, max_addr;
    bit   valid_seen, enbl_seen, prev_stall;
    logic [7:0] prev_byte;

    log_ram_reader #(
        .RAM_WIDTH(32), .RAM_DEPTH(DEPTH), .ADDR_W(AW), .RAM_LATENCY(1)
    ) dut (
        .i_clock(clk), .i_reset(rst_n), .i_start(i_start), .i_n_words(i_n_words),
        .i_abort(i_abort), .o_enbl_read(o_enbl_read), .o_read_adrs(o_read_adrs),
        .i_ram_data(ram_q), .o_byte(o_byte), .o_byte_valid(o_byte_valid),
        .i_byte_ready(i_byte_ready), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    // One-cycle-latency RAM read port
    always @(posedge clk) ram_q <= mem[int'(o_read_adrs) % DEPTH];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int n;
        int mode;      // 0: ready high, 1: toggle, 2: toggle plus random stalls
        int poke;      // cycle at which a stray i_start is issued (0: none)
        bit with_abort;
        int exp_done;  // expected done cycle after start edge, -1: only require completion
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got_bytes.delete();
        addr_err = 0; stab_err = 0; enbl_gap = 0; max_addr = -1;
        valid_seen = 0; enbl_seen = 0; prev_stall = 0; prev_byte = '0;
    endtask

    task automatic drive_and_monitor(input int mode, input int cyc);
        case (mode)
            0: i_byte_ready = 1'b1;
            1: i_byte_ready = (cyc % 2 == 0);
            default: i_byte_ready = (cyc % 2 == 0) ? ($urandom_range(0, 3) != 0) : 1'b0;
        endcase
        if (prev_stall && (!o_byte_valid || o_byte !== prev_byte)) stab_err++;
        prev_stall = o_byte_valid && !i_byte_ready;
        prev_byte  = o_byte;
        if (o_enbl_read) begin
            enbl_seen = 1;
            if (int'(o_read_adrs) > max_addr) max_addr = int'(o_read_adrs);
        end
        if (o_byte_valid) valid_seen = 1;
        if (o_busy && !o_done && !o_enbl_read) enbl_gap++;
        if (o_byte_valid && i_byte_ready) begin
            if (int'(o_read_adrs) != got_bytes.size() / 4) addr_err++;
            got_bytes.push_back(o_byte);
        end
    endtask

    task automatic run_dump(input int n, input int mode, input int poke, input bit with_abort,
                            output int done_cyc);
        int neff;
        neff = (n > DEPTH) ? DEPTH : n;
        clear_mon();
        i_start   = 1'b1;
        i_n_words = AW'(n);
        i_abort   = with_abort;
        tick();
        i_start   = 1'b0;
        i_abort   = 1'b0;
        i_n_words = AW'($urandom_range(0, 65535));
        check("start_latency", {o_busy, o_enbl_read, o_done, o_read_adrs},
              {(neff > 0) ? 3'b110 : 3'b101, 16'h0});
        done_cyc = -1;
        for (int cyc = 1; cyc <= LIMIT; cyc++) begin
            if (o_done) begin
                done_cyc = cyc;
                break;
            end
            i_start = (cyc == poke);
            if (cyc == poke) i_n_words = 16'd1;
            drive_and_monitor(mode, cyc);
            tick();
        end
        i_start = 1'b0;
        i_byte_ready = 1'b0;
        tick();
    endtask

    task automatic verify(input string name, input int n, input int exp_done, input int done_cyc);
        int neff, bad;
        logic [7:0] eb;
        neff = (n > DEPTH) ? DEPTH : n;
        bad = 0;
        for (int i = 0; i < got_bytes.size() && i < neff * 4; i++) begin
            eb = mem[i / 4][31 - 8 * (i % 4) -: 8];
            if (got_bytes[i] !== eb) bad++;
        end
        check({name, "_nbytes"}, 64'(got_bytes.size()), 64'(neff * 4));
        check({name, "_byte_errs"}, 64'(bad), 64'd0);
        check({name, "_addr_errs"}, 64'(addr_err), 64'd0);
        check({name, "_stable_errs"}, 64'(stab_err), 64'd0);
        check({name, "_enbl_gaps"}, 64'(enbl_gap), 64'd0);
        if (neff > 0)
            check({name, "_max_addr"}, 64'(max_addr), 64'(neff - 1));
        else
            check({name, "_no_read_no_valid"}, {63'd0, enbl_seen | valid_seen}, 64'd0);
        if (exp_done >= 0)
            check({name, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
        else
            check({name, "_completed"}, {63'd0, done_cyc > 0}, 64'd1);
        check({name, "_idle_after"}, {61'd0, o_busy, o_enbl_read, o_done}, 64'd0);
    endtask

    vec_t vecs [9];

    initial begin
        int dc;
        bit done_flag;

        vecs[0] = '{n: 3,   mode: 0, poke: 0, with_abort: 0, exp_done: 19};
        vecs[1] = '{n: 3,   mode: 1, poke: 0, with_abort: 0, exp_done: -1};
        vecs[2] = '{n: 3,   mode: 2, poke: 0, with_abort: 0, exp_done: -1};
        vecs[3] = '{n: 0,   mode: 0, poke: 0, with_abort: 0, exp_done: 1};
        vecs[4] = '{n: 1,   mode: 0, poke: 0, with_abort: 0, exp_done: 7};
        vecs[5] = '{n: 4,   mode: 0, poke: 9, with_abort: 0, exp_done: 25};
        vecs[6] = '{n: 2,   mode: 0, poke: 0, with_abort: 1, exp_done: 13};
        vecs[7] = '{n: 100, mode: 0, poke: 0, with_abort: 0, exp_done: 6 * DEPTH + 1};
        vecs[8] = '{n: 64,  mode: 2, poke: 0, with_abort: 0, exp_done: -1};

        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[0] = 32'h11223344;
        mem[1] = 32'hAABBCCDD;
        mem[2] = 32'h01020304;

        rst_n = 1'b0; i_start = 1'b0; i_n_words = '0; i_abort = 1'b0; i_byte_ready = 1'b0;
        tick(); tick();
        check("reset_outputs", {o_enbl_read, o_read_adrs, o_byte, o_byte_valid, o_busy, o_done}, '0);
        rst_n = 1'b1;
        tick();

        // Idle abort must not start anything
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check("idle_abort", {o_busy, o_enbl_read, o_done}, 3'b000);

        // Asynchronous reset while a byte is on offer
        clear_mon();
        i_start = 1'b1; i_n_words = 16'd3;
        tick();
        i_start = 1'b0;
        for (int c = 0; c < 10 && !o_byte_valid; c++) tick();
        check("mid_reset_valid_reached", {63'd0, o_byte_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", {o_enbl_read, o_read_adrs, o_byte, o_byte_valid, o_busy, o_done}, '0);
        tick();
        rst_n = 1'b1;
        tick();
        run_dump(1, 0, 0, 0, dc);
        verify("after_reset", 1, 7, dc);

        for (int v = 0; v < 9; v++) begin
            run_dump(vecs[v].n, vecs[v].mode, vecs[v].poke, vecs[v].with_abort, dc);
            verify($sformatf("vec%0d", v), vecs[v].n, vecs[v].exp_done, dc);
        end

        // Abort while word 5's second byte is on offer
        clear_mon();
        i_start = 1'b1; i_n_words = 16'd8;
        tick();
        i_start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (o_byte_valid && got_bytes.size() == 21) break;
            drive_and_monitor(0, c);
            tick();
        end
        check("abort_point_reached", {63'd0, o_byte_valid}, 64'd1);
        check("abort_bytes_before", 64'(got_bytes.size()), 64'd21);
        check("abort_byte_value", {56'd0, o_byte}, {56'd0, mem[5][23:16]});
        i_abort = 1'b1; i_byte_ready = 1'b0;
        tick();
        i_abort = 1'b0;
        check("abort_next_cycle", {o_busy, o_byte_valid, o_enbl_read, o_done}, 4'b0000);
        done_flag = 0;
        for (int c = 0; c < 4; c++) begin
            if (o_done || o_busy) done_flag = 1;
            tick();
        end
        check("abort_stays_idle", {63'd0, done_flag}, 64'd0);
        run_dump(2, 0, 0, 0, dc);
        check("restart_first_byte", {56'd0, got_bytes[0]}, {56'd0, mem[0][31:24]});
        verify("restart", 2, 13, dc);

        // Randomized dumps against the byte-stream model
        for (int r = 0; r < 6; r++) begin
            int n, mode, neff;
            for (int i = 3; i < DEPTH; i++) mem[i] = $urandom;
            n    = $urandom_range(0, 70);
            mode = $urandom_range(0, 2);
            neff = (n > DEPTH) ? DEPTH : n;
            run_dump(n, mode, 0, 0, dc);
            verify($sformatf("rand%0d", r), n, (mode == 0) ? 6 * neff + 1 : -1, dc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/log_ram_reader.md
# log_ram_reader

Drains the capture block RAM filled by the FSE/slicer/coefficient logger and streams its contents out as bytes over a valid/ready handshake, normally into the UART transmitter toward the host. It owns the RAM read port: it drives the read enable and read address, captures each RAM word after the RAM read latency, and serializes it MSB byte first. While it holds the read enable high, the logger's write address counter is held at zero, so a dump always freezes and rewinds the capture.

## Interface

Parameters:
- RAM_WIDTH, 32, RAM word width; must be a multiple of 8.
- RAM_DEPTH, 32000, number of RAM words; upper bound on any dump length.
- ADDR_W, 16, read address and word-count width.
- RAM_LATENCY, 1, read latency in cycles from address to data.
  - 1 for "LOW_LATENCY", 2 for "HIGH_PERFORMANCE".
  - Other values are illegal.

Ports:
- i_clock  in  1  system clock; all logic is on the rising edge.
- i_reset  in  1  asynchronous, active-low reset; one clock, no other reset.
- i_start  in  1  one-cycle request to begin a dump; honoured only in IDLE.
- i_n_words  in  ADDR_W  number of words to dump from address 0; latched on an accepted i_start.
- i_abort  in  1  terminates a dump in progress.
- o_enbl_read  out  1  RAM read enable.
- o_read_adrs  out  ADDR_W  RAM read address.
- i_ram_data  in  RAM_WIDTH  RAM read data.
- o_byte  out  8  output byte.
- o_byte_valid  out  1  o_byte is valid.
- i_byte_ready  in  1  sink accepts o_byte this cycle.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse when a dump completes normally.

## Operation

- **States:** IDLE, READ, WAIT, SEND, DONE.
- **IDLE**
  - i_start=1 latches N = min(i_n_words, RAM_DEPTH), clears the word count and address, and goes to READ.
  - If N=0, it goes directly to DONE without asserting o_enbl_read.
- **READ** (1 cycle): o_read_adrs = current address, then go to WAIT.
- **WAIT** (RAM_LATENCY cycles): on the last WAIT cycle, i_ram_data is loaded into the shift register and the byte index is cleared. Then go to SEND.
- **SEND**
  - o_byte_valid=1 and o_byte = the shift register's top byte (bits RAM_WIDTH-1 down to RAM_WIDTH-8).
  - On each cycle with o_byte_valid and i_byte_ready both high, shift left 8 and increment the byte index.
  - After the RAM_WIDTH/8-th transfer, increment the word count:
    - if count == N, go to DONE;
    - otherwise increment the address and go to READ.
- **DONE** (1 cycle): o_done=1, then go to IDLE.
- **o_enbl_read** is 1 in READ, WAIT and SEND and 0 in IDLE and DONE. It is continuous for the whole dump, so the logger stays paused and rewound throughout.
- **Handshake**
  - Once o_byte_valid rises, o_byte stays stable and valid stays high until the transfer.
  - A single byte is never emitted twice or dropped.
  - The sink may hold i_byte_ready high before valid rises.
- **Abort:** i_abort=1 in any non-IDLE state goes to IDLE at the next edge.
  - o_byte_valid and o_enbl_read drop and o_done is not pulsed.
  - i_abort in IDLE has no effect. If i_abort and i_start arrive together in IDLE, the start is honoured.
- i_start outside IDLE is ignored, and i_n_words is not re-latched.
- The address never exceeds N-1, and so never exceeds RAM_DEPTH-1. There is no wrap-around.

## Timing

- **Reset values:** o_enbl_read=0, o_read_adrs=0, o_byte=0, o_byte_valid=0, o_busy=0, o_done=0; state IDLE; internal counters 0.
- **Reset mid-dump:** clears everything asynchronously. The next dump starts again from address 0.
- **Start latency:** i_start accepted at edge k puts the FSM in READ during cycle k+1, with o_enbl_read=1 and o_read_adrs=0.
- **Per-word cost** with i_byte_ready held high: 1 (READ) + RAM_LATENCY (WAIT) + RAM_WIDTH/8 (SEND) cycles.
  - That is 6 cycles at the defaults.
- **Total dump:** N words take 6N cycles from the first READ cycle to the last byte transfer. o_done is high in the following cycle, and o_busy falls together with o_done.
- o_read_adrs holds its value from READ through SEND of the same word.

## Test plan

- **Reset:** assert i_reset=0 mid-dump while o_byte_valid=1 → all outputs 0 immediately. After release, i_start with N=1 reads address 0.
- **Normal dump:** RAM model with RAM_LATENCY=1 preloaded 0x11223344, 0xAABBCCDD, 0x01020304; i_n_words=3; ready always 1.
  - Bytes out: 11 22 33 44 AA BB CC DD 01 02 03 04.
  - Addresses 0, 1, 2.
  - o_done exactly 19 cycles after the i_start edge; o_enbl_read continuously high over the dump.
- **Backpressure:** same data with i_byte_ready toggling 1/0 per cycle plus random stalls → identical 12-byte sequence, and o_byte constant while valid=1 and ready=0.
- **Zero length:** i_n_words=0 → o_done pulses in cycle k+1; o_enbl_read and o_byte_valid never rise.
- **Abort and restart:** abort during the second byte of word 5 → next cycle idle with no o_done. Restart with N=2 → first byte is word 0's MSB.
- **Clamping and start while busy:** i_n_words=40000 → last address 31999, 128000 bytes out. A second i_start during the dump is ignored.
